// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for one data-memory port (cpu vs ext), with a timeout watchdog.
// Latency: req->ack is 3 cycles minimum; requesters hold req until ack (cpu gets a combinational stall).
module dmem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [2:0]    cpu_dm_type,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  input  logic [2:0]    ext_dm_type,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  output logic          ext_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_dm_type,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_EXT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_ext;
  logic          cpu_elig;
  logic          ext_elig;
  logic          grant_cpu;
  logic          grant_ext;
  logic          done;

  // A port is not eligible in its own ack cycle, so its held req is not re-served.
  assign cpu_elig  = cpu_req & ~cpu_ack;
  assign ext_elig  = ext_req & ~ext_ack;
  assign grant_cpu = cpu_elig & (~ext_elig | last_ext);
  assign grant_ext = ext_elig & (~cpu_elig | ~last_ext);
  assign done      = mem_ack | (cnt == CW'(TIMEOUT - 1));
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_ext    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_dm_type <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      ext_rdata   <= '0;
      ext_ack     <= 1'b0;
      ext_err     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      ext_ack <= 1'b0;
      ext_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_cpu) begin
            state       <= BUSY_CPU;
            last_ext    <= 1'b0;
            mem_req     <= 1'b1;
            mem_we      <= cpu_we;
            mem_addr    <= cpu_addr;
            mem_wdata   <= cpu_wdata;
            mem_dm_type <= cpu_dm_type;
          end else if (grant_ext) begin
            state       <= BUSY_EXT;
            last_ext    <= 1'b1;
            mem_req     <= 1'b1;
            mem_we      <= ext_we;
            mem_addr    <= ext_addr;
            mem_wdata   <= ext_wdata;
            mem_dm_type <= ext_dm_type;
          end
        end
        BUSY_CPU, BUSY_EXT: begin
          // mem_ack takes priority over expiry; an abort returns zero data with err set.
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            cnt     <= '0;
            if (state == BUSY_CPU) begin
              cpu_ack   <= 1'b1;
              cpu_err   <= ~mem_ack;
              cpu_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              ext_ack   <= 1'b1;
              ext_err   <= ~mem_ack;
              ext_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small wait-state memory responder.
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [2:0]  cpu_dm_type, ext_dm_type;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        cpu_ack, cpu_err, cpu_stall, ext_ack, ext_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_dm_type;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  // memory responder configuration, written only by the test sequence
  int          mem_wait  = 0;
  logic        mem_never = 1'b0;
  logic        stale     = 1'b0;
  logic [31:0] mem_data  = 32'h0;
  int          req_cycles = 0;

  dmem_arbiter #(.TIMEOUT(16), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_dm_type(cpu_dm_type), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_dm_type(ext_dm_type), .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_err(ext_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dm_type(mem_dm_type), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Acks in the (mem_wait+1)-th consecutive cycle of mem_req; stale forces a one-off ack.
  always @(negedge clk) begin
    if (mem_req) req_cycles = req_cycles + 1;
    else         req_cycles = 0;
    mem_ack   = stale | (mem_req & ~mem_never & (req_cycles == mem_wait + 1));
    mem_rdata = mem_data;
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_dm_type = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_dm_type = 0;
    mem_ack = 0; mem_rdata = 0;
    do_reset();
    total++;
    if ({mem_req, mem_we, cpu_ack, cpu_err, ext_ack, ext_err, cpu_stall} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                      {mem_req, mem_we, cpu_ack, cpu_err, ext_ack, ext_err, cpu_stall});
    end
    total++;
    if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, ext_rdata});
    end
  endtask

  task automatic test_zero_wait_read;
    mem_wait = 0; mem_data = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_dm_type = 3'd2;
    #1;
    total++;
    if (cpu_stall !== 1'b1) begin bad++; $display("FAIL zw_stall0: got %b want 1", cpu_stall); end
    step();
    total++;
    if ({mem_req, cpu_stall, cpu_ack} !== 3'b110 || mem_addr !== 32'h100 || mem_dm_type !== 3'd2) begin
      bad++; $display("FAIL zw_grant: req/stall/ack=%b addr=%h dm=%0d want 110 100 2",
                      {mem_req, cpu_stall, cpu_ack}, mem_addr, mem_dm_type);
    end
    step();
    total++;
    if ({cpu_ack, cpu_err, mem_req, cpu_stall} !== 4'b1000 || cpu_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL zw_ack: ack/err/req/stall=%b rdata=%h want 1000 deadbeef",
                      {cpu_ack, cpu_err, mem_req, cpu_stall}, cpu_rdata);
    end
    cpu_req = 0;
    step();
    total++;
    if ({cpu_ack, mem_req} !== 2'b00) begin
      bad++; $display("FAIL zw_after: ack/req=%b want 00", {cpu_ack, mem_req});
    end
  endtask

  task automatic test_tie_from_reset;
    do_reset();
    mem_wait = 2; mem_data = 32'hA0A00020;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h55;
    ext_req = 1; ext_we = 0; ext_addr = 32'h20;
    step();
    total++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h10 || mem_wdata !== 32'h55) begin
      bad++; $display("FAIL tie_cpu_first: req/we=%b addr=%h wdata=%h want 11 10 55",
                      {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    step();
    step();
    total++;
    if ({mem_req, cpu_ack} !== 2'b10) begin
      bad++; $display("FAIL tie_cpu_wait: req/ack=%b want 10", {mem_req, cpu_ack});
    end
    step();
    total++;
    if ({cpu_ack, cpu_err, ext_ack} !== 3'b100) begin
      bad++; $display("FAIL tie_cpu_ack: ack/err/ext_ack=%b want 100", {cpu_ack, cpu_err, ext_ack});
    end
    cpu_req = 0;
    step();
    total++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h20) begin
      bad++; $display("FAIL tie_ext_next: req/we=%b addr=%h want 10 20", {mem_req, mem_we}, mem_addr);
    end
    step(); step(); step();
    total++;
    if ({ext_ack, ext_err} !== 2'b10 || ext_rdata !== 32'hA0A00020) begin
      bad++; $display("FAIL tie_ext_ack: ack/err=%b rdata=%h want 10 a0a00020", {ext_ack, ext_err}, ext_rdata);
    end
    ext_req = 0;
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    ext_req = 1; ext_addr = 32'h40;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin
      bad++; $display("FAIL tie_second: req=%b addr=%h want 1 30", mem_req, mem_addr);
    end
    cpu_req = 0; ext_req = 0;
    do_reset();
  endtask

  task automatic test_contention;
    int n_grant = 0, n_cpu = 0, n_ext = 0;
    logic prev = 1'b0;
    logic [31:0] want;
    mem_wait = 1; mem_data = 32'h0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC0;
    ext_req = 1; ext_we = 0; ext_addr = 32'hE0;
    for (int i = 0; i < 200 && (n_cpu + n_ext) < 8; i++) begin
      step();
      if (mem_req && !prev) begin
        want = (n_grant % 2 == 0) ? 32'hC0 : 32'hE0;
        total++;
        if (mem_addr !== want) begin
          bad++; $display("FAIL rr_grant%0d: addr=%h want %h", n_grant, mem_addr, want);
        end
        n_grant++;
      end
      prev = mem_req;
      if (cpu_ack) n_cpu++;
      if (ext_ack) n_ext++;
    end
    total++;
    if (n_cpu != 4 || n_ext != 4) begin
      bad++; $display("FAIL rr_counts: cpu=%0d ext=%0d want 4/4", n_cpu, n_ext);
    end
    cpu_req = 0; ext_req = 0;
    do_reset();
  endtask

  task automatic test_timeout;
    int n = 0;
    logic got = 1'b0;
    mem_never = 1; mem_data = 32'h11111111;
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ext_ack) begin got = 1'b1; break; end
      if (mem_req) n++;
    end
    total++;
    if (!got || n != 16) begin
      bad++; $display("FAIL to_len: acked=%b req_cycles=%0d want 1 16", got, n);
    end
    total++;
    if ({ext_err, mem_req, cpu_ack} !== 3'b100 || ext_rdata !== 32'h0) begin
      bad++; $display("FAIL to_abort: err/req/cpu_ack=%b rdata=%h want 100 0",
                      {ext_err, mem_req, cpu_ack}, ext_rdata);
    end
    ext_req = 0;
    mem_never = 0;
    step(); step();
    stale = 1'b1;
    step();
    stale = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ext_ack, cpu_ack, mem_req} !== 3'b000) begin
        bad++; $display("FAIL to_stale%0d: ext_ack/cpu_ack/req=%b want 000", i, {ext_ack, cpu_ack, mem_req});
      end
      step();
    end
  endtask

  task automatic test_expiry_boundary;
    int n = 0;
    logic got = 1'b0;
    mem_wait = 15; mem_data = 32'h5A5A5A5A;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cpu_ack) begin got = 1'b1; break; end
      if (mem_req) n++;
    end
    total++;
    if (!got || n != 16) begin
      bad++; $display("FAIL edge_len: acked=%b req_cycles=%0d want 1 16", got, n);
    end
    total++;
    if (cpu_err !== 1'b0 || cpu_rdata !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL edge_ack: err=%b rdata=%h want 0 5a5a5a5a", cpu_err, cpu_rdata);
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_reset_midflight;
    mem_wait = 4; mem_data = 32'h0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60;
    step();
    step();
    step();
    total++;
    if ({mem_req, cpu_ack} !== 2'b10) begin
      bad++; $display("FAIL rst_busy: req/ack=%b want 10", {mem_req, cpu_ack});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_req, cpu_ack} !== 2'b00) begin
      bad++; $display("FAIL rst_async: req/ack=%b want 00", {mem_req, cpu_ack});
    end
    ext_req = 1; ext_we = 0; ext_addr = 32'h70;
    step();
    total++;
    if ({mem_req, cpu_ack} !== 2'b00) begin
      bad++; $display("FAIL rst_held: req/ack=%b want 00", {mem_req, cpu_ack});
    end
    reset = 1'b0;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h60 || cpu_ack !== 1'b0) begin
      bad++; $display("FAIL rst_tie: req=%b addr=%h ack=%b want 1 60 0", mem_req, mem_addr, cpu_ack);
    end
    cpu_req = 0; ext_req = 0;
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_zero_wait_read();
    test_tie_from_reset();
    test_contention();
    test_timeout();
    test_expiry_boundary();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (port cpu) and an external/debug requester (port ext).
- Round-robin grant, registered memory-side request, and a timeout watchdog.
- Drives a combinational stall to the pipeline while the CPU access is outstanding.
- Sits between the core's Addr_out/Data_out/mem_w/dm_type outputs and the data memory.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before the access is aborted with error.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_dm_type  in  3  CPU access size/sign code, passed through unchanged
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  timeout error, valid with cpu_ack
- cpu_stall  out  1  pipeline stall
- ext_req, ext_we, ext_addr, ext_wdata, ext_dm_type  in  1/1/AW/DW/3  external requester; same meaning as the cpu_* inputs
- ext_rdata, ext_ack, ext_err  out  DW/1/1  external response; same meaning as the cpu_* outputs
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_dm_type  out  3  memory access size/sign code
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-high, on port reset.
- Reset values:
  - All outputs 0 except cpu_stall, which follows its combinational equation.
  - State IDLE, timeout counter 0, last_grant = ext (so the CPU wins the first tie).
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_CPU, BUSY_EXT: transaction outstanding for that port.
- IDLE transitions:
  - Only cpu_req is eligible -> BUSY_CPU.
  - Only ext_req is eligible -> BUSY_EXT.
  - Both eligible -> grant the port opposite last_grant, then update last_grant.
  - Payload (we/addr/wdata/dm_type) of the granted port is latched into mem_* registers on the grant edge.
  - mem_req is high from the next cycle.
- BUSY transitions:
  - mem_req stays high and mem_* stays stable.
  - The counter increments each cycle mem_req=1 and mem_ack=0.
- Completion:
  - On mem_ack: latch mem_rdata into the granted port's rdata and pulse its ack with err=0 on the next cycle.
  - mem_req drops in that same next cycle. State returns to IDLE. Counter is cleared.
  - Write accesses also return ack; rdata for a write is don't-care and the bench must not check it.
- Timeout:
  - If the counter reaches TIMEOUT-1 with mem_ack=0, the next cycle pulses ack with err=1 and rdata=0.
  - mem_req drops. State returns to IDLE.
  - If mem_ack coincides with the expiry cycle, mem_ack wins: normal completion, err=0.
- Stale ack: mem_ack while in IDLE (late ack after an abort) is ignored; no ack pulse.
- Eligibility rule:
  - In the cycle a port's ack is high, that port's req is not eligible for arbitration.
  - The other port may be granted in that same cycle. Back-to-back transactions are therefore possible with no idle cycle.
- Latency: minimum is 3 cycles from req to ack, with zero-wait memory (mem_ack the first cycle mem_req is high). Sequence: req sampled at edge N, mem_req high N+1, mem_ack N+1, ack at N+2.
- Requester rule: req and payload must remain stable from assertion until ack. Changes mid-transaction have no effect because the payload is latched.
- cpu_stall = cpu_req & ~cpu_ack (combinational). Stall is low in the ack cycle so the pipeline advances exactly once per completed access.
- Widths: the counter is ceil(log2(TIMEOUT+1)) bits and saturates at TIMEOUT-1; it never wraps.
- Reset mid-transaction: the in-flight access is discarded and no ack is issued. mem_req goes low immediately (asynchronously).

Test Plan:
1. Zero-wait CPU read:
   - Stimulus: cpu_req=1, addr=0x100, we=0; memory acks the first mem_req cycle with rdata=0xDEADBEEF.
   - Required: mem_req high 1 cycle, mem_addr=0x100; cpu_ack pulse 1 cycle with cpu_rdata=0xDEADBEEF, cpu_err=0; cpu_stall high 2 cycles then low.
2. Simultaneous requests from reset:
   - Stimulus: cpu write addr=0x10, ext read addr=0x20, both raised the same cycle; memory has 2 wait states.
   - Required: CPU served first (mem_addr=0x10, mem_we=1), then ext (mem_addr=0x20) immediately after cpu_ack. A second tie goes to the CPU again because last_grant=ext.
3. Continuous contention:
   - Stimulus: both requesters re-request immediately after every ack, for 8 transactions.
   - Required: grants strictly alternate cpu, ext, cpu, ext...; no starvation; ack counts 4/4.
4. Timeout with TIMEOUT=16:
   - Stimulus: ext read; memory never acks.
   - Required: mem_req high exactly 16 cycles; ext_ack=1 with ext_err=1, ext_rdata=0; a late mem_ack 3 cycles after the abort is ignored.
5. Ack at the expiry boundary:
   - Stimulus: mem_ack arrives in the 16th mem_req cycle with rdata=0x5A5A5A5A.
   - Required: normal completion with err=0, rdata=0x5A5A5A5A.
6. Reset mid-transaction:
   - Stimulus: assert reset during BUSY_CPU with 3 wait states remaining.
   - Required: mem_req=0 immediately; no cpu_ack; after release the first tie is granted to the CPU.
